// File: rtl/muldiv_pkg.sv
// Shared types and encodings for the MULT/DIV sequencer and its watchdog counter.
package muldiv_pkg;

    localparam int CNT_W = 6;

    localparam logic OP_MULT  = 1'b0;
    localparam logic OP_DIV   = 1'b1;
    localparam logic SEL_MULT = 1'b0;
    localparam logic SEL_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RUN_MULT,
        RUN_DIV,
        WRITEBACK,
        EXC_DZ
    } seqState;

    function automatic logic kindToSel(input logic kind);
        return (kind == OP_DIV) ? SEL_DIV : SEL_MULT;
    endfunction

endpackage

// File: rtl/muldiv_watchdog.sv
// Saturating RUN-cycle counter with clear/enable and a CYCLE_LIMIT-1 compare flag.
module muldiv_watchdog
    import muldiv_pkg::*;
#(
    parameter int CYCLE_LIMIT = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             limitHit
);

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign limitHit = (count == CNT_W'(CYCLE_LIMIT - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// Control FSM that launches the iterative multiplier/divider and commits HI/LO
// or raises divide-by-zero / watchdog exceptions back to the control unit.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int CYCLE_LIMIT = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic             op_is_div,
    input  logic             divisor_zero,
    input  logic             flush,
    output logic             op_ready,
    output logic             busy,
    output logic             mult_start,
    input  logic             mult_done,
    output logic             div_start,
    input  logic             div_done,
    output logic             MultOrDivHigh,
    output logic             MultOrDivLow,
    output logic             HIWrite,
    output logic             LOWrite,
    output logic             done,
    output logic             div_zero_exc,
    output logic             timeout_exc,
    output logic [CNT_W-1:0] last_cycles
);

    seqState          state, nextState;
    logic             opKind;
    logic             timeoutReg;
    logic             accept;
    logic             captureLast;
    logic             nextTimeout;
    logic             wdClear, wdEnable;
    logic [CNT_W-1:0] wdCount;
    logic             wdLimitHit;
    logic             firstRun;
    logic             doneSeen;
    logic             wbCommit;

    muldiv_watchdog #(.CYCLE_LIMIT(CYCLE_LIMIT)) uWatchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (wdClear),
        .enable   (wdEnable),
        .count    (wdCount),
        .limitHit (wdLimitHit)
    );

    // The counter is zero only in the first RUN cycle, which doubles as the start-pulse cycle.
    assign firstRun = (wdCount == '0);
    assign doneSeen = !firstRun &&
                      (((state == RUN_MULT) && mult_done) || ((state == RUN_DIV) && div_done));

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        nextState   = state;
        accept      = 1'b0;
        captureLast = 1'b0;
        nextTimeout = 1'b0;
        wdClear     = 1'b0;
        wdEnable    = 1'b0;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    accept  = 1'b1;
                    wdClear = 1'b1;
                    if (!op_is_div)       nextState = RUN_MULT;
                    else if (divisor_zero) nextState = EXC_DZ;
                    else                   nextState = RUN_DIV;
                end
            end
            RUN_MULT, RUN_DIV: begin
                wdEnable = 1'b1;
                if (flush) begin
                    nextState = IDLE;
                end else if (doneSeen) begin
                    nextState   = WRITEBACK;
                    captureLast = 1'b1;
                end else if (wdLimitHit) begin
                    nextState   = IDLE;
                    nextTimeout = 1'b1;
                end
            end
            WRITEBACK: nextState = IDLE;
            EXC_DZ:    nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            opKind      <= OP_MULT;
            timeoutReg  <= 1'b0;
            last_cycles <= '0;
        end else begin
            state      <= nextState;
            timeoutReg <= nextTimeout;
            if (accept)      opKind      <= op_is_div ? OP_DIV : OP_MULT;
            if (captureLast) last_cycles <= wdCount;
        end
    end

    // A same-cycle flush must cancel the commit, so the write strobes are the one input-gated output.
    assign wbCommit = (state == WRITEBACK) && !flush;

    assign op_ready      = (state == IDLE);
    assign busy          = (state == RUN_MULT) || (state == RUN_DIV) || (state == WRITEBACK);
    assign mult_start    = (state == RUN_MULT) && firstRun;
    assign div_start     = (state == RUN_DIV) && firstRun;
    assign HIWrite       = wbCommit;
    assign LOWrite       = wbCommit;
    assign done          = wbCommit;
    assign div_zero_exc  = (state == EXC_DZ);
    assign timeout_exc   = timeoutReg;
    assign MultOrDivHigh = kindToSel(opKind);
    assign MultOrDivLow  = kindToSel(opKind);

endmodule
